pim_mem_dispatcher: RTL and testbench

- Parametrised successor to the PIM operand memory.
- Holds the operand/result memory array and accepts one vector job at a time: source A, source B, destination, length.
- Streams element pairs (A[k], B[k]) round-robin to up to NUM_PIMS PIM channels over a valid/ready handshake.
- Collects the per-element results in order and writes them back to destination memory; pulses done when the last write commits.

---
 rtl/pim_mem_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_pim_mem_dispatcher.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_mem_dispatcher.sv
// Operand/result memory that streams vector element pairs to PIM channels
// round-robin and writes the per-element results back in element order.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   host_*            host write (IDLE only) and registered read
//   cmd_* / src_*     job request: operand bases, dest base, size, channels
//   busy, done        job in progress / one-cycle completion pulse
//   pim_req_*         one-hot request valid/ready, broadcast operands
//   pim_rsp_*         per-channel result valid/data, one-hot accept
module pim_mem_dispatcher #(
  parameter int WIDTH    = 16,
  parameter int MEM_SIZE = 256,
  parameter int LEN      = $clog2(MEM_SIZE),
  parameter int MAX_SIZE = 64,
  parameter int SZW      = $clog2(MAX_SIZE+1),
  parameter int NUM_PIMS = 4,
  parameter int PW       = $clog2(NUM_PIMS+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_we,
  input  logic [LEN-1:0]            host_addr,
  input  logic [WIDTH-1:0]          host_wdata,
  output logic [WIDTH-1:0]          host_rdata,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [LEN-1:0]            src_addr_a,
  input  logic [LEN-1:0]            src_addr_b,
  input  logic [LEN-1:0]            dest_addr,
  input  logic [SZW-1:0]            size,
  input  logic [PW-1:0]             no_of_pims,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_PIMS-1:0]       pim_req_valid,
  input  logic [NUM_PIMS-1:0]       pim_req_ready,
  output logic [WIDTH-1:0]          pim_req_a,
  output logic [WIDTH-1:0]          pim_req_b,
  input  logic [NUM_PIMS-1:0]       pim_rsp_valid,
  input  logic [NUM_PIMS*WIDTH-1:0] pim_rsp_data,
  output logic [NUM_PIMS-1:0]       pim_rsp_ready
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [SZW-1:0]   i_q, i_d, j_q, j_d;
  logic [SZW-1:0]   size_q, size_d;
  logic [PW-1:0]    np_q, np_d;
  logic [PW-1:0]    ci_q, ci_d, cj_q, cj_d;
  logic [LEN-1:0]   sa_q, sa_d, sb_q, sb_d;
  logic [LEN-1:0]   da_q, da_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [WIDTH-1:0] mem [MEM_SIZE];

  logic                mem_we;
  logic [LEN-1:0]      mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [NUM_PIMS-1:0] req_oh, rsp_oh;
  logic [WIDTH-1:0]    rsp_sel;
  logic                issue_ok, issue_fire;
  logic                coll_ok, coll_fire;

  // ci/cj are rotating channel pointers, equal to i mod nP and j mod nP
  always_comb begin
    req_oh  = '0;
    rsp_oh  = '0;
    rsp_sel = '0;
    for (int c = 0; c < NUM_PIMS; c++) begin
      if (ci_q == PW'(c)) req_oh[c] = 1'b1;
      if (cj_q == PW'(c)) begin
        rsp_oh[c] = 1'b1;
        rsp_sel   = pim_rsp_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // the i-j window bounds each channel to one request in flight
  assign issue_ok = (state_q == RUN) && (i_q < size_q) &&
                    ((i_q - j_q) < SZW'(np_q));
  assign issue_fire = issue_ok && |(req_oh & pim_req_ready);
  assign coll_ok    = (state_q == RUN) && (j_q < i_q);
  assign coll_fire  = coll_ok && |(rsp_oh & pim_rsp_valid);

  assign pim_req_valid = issue_ok ? req_oh : '0;
  assign pim_rsp_ready = coll_ok ? rsp_oh : '0;
  assign pim_req_a     = mem[sa_q + LEN'(i_q)];
  assign pim_req_b     = mem[sb_q + LEN'(i_q)];

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == FIN);
  assign host_rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    size_d    = size_q;
    np_d      = np_q;
    ci_d      = ci_q;
    cj_d      = cj_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    da_d      = da_q;
    rdata_d   = mem[host_addr];
    mem_we    = 1'b0;
    mem_waddr = host_addr;
    mem_wdata = host_wdata;
    unique case (state_q)
      IDLE: begin
        mem_we = host_we;
        if (cmd_valid) begin
          sa_d = src_addr_a;
          sb_d = src_addr_b;
          da_d = dest_addr;
          size_d = (size > SZW'(MAX_SIZE)) ? SZW'(MAX_SIZE) : size;
          if (no_of_pims == '0)
            np_d = PW'(1);
          else if (no_of_pims > PW'(NUM_PIMS))
            np_d = PW'(NUM_PIMS);
          else
            np_d = no_of_pims;
          i_d  = '0;
          j_d  = '0;
          ci_d = '0;
          cj_d = '0;
          state_d = (size_d == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue_fire) begin
          i_d  = i_q + SZW'(1);
          ci_d = (ci_q == np_q - PW'(1)) ? '0 : ci_q + PW'(1);
        end
        if (coll_fire) begin
          mem_we    = 1'b1;
          mem_waddr = da_q + LEN'(j_q);
          mem_wdata = rsp_sel;
          j_d  = j_q + SZW'(1);
          cj_d = (cj_q == np_q - PW'(1)) ? '0 : cj_q + PW'(1);
          if (j_q == size_q - SZW'(1)) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      size_q  <= '0;
      np_q    <= '0;
      ci_q    <= '0;
      cj_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      da_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      size_q  <= size_d;
      np_q    <= np_d;
      ci_q    <= ci_d;
      cj_q    <= cj_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      da_q    <= da_d;
      rdata_q <= rdata_d;
    end
  end

  // contents survive reset; no write lands in a reset cycle
  always_ff @(posedge clk) begin
    if (mem_we && rst) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_pim_mem_dispatcher.sv
// Randomized bench for pim_mem_dispatcher with channel models
// and a reference memory/job model.
module tb_pim_mem_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  src_addr_a, src_addr_b, dest_addr;
  logic [6:0]  size;
  logic [2:0]  no_of_pims;
  logic        busy, done;
  logic [3:0]  pim_req_valid, pim_req_ready;
  logic [15:0] pim_req_a, pim_req_b;
  logic [3:0]  pim_rsp_valid, pim_rsp_ready;
  logic [63:0] pim_rsp_data;

  always #5 clk = ~clk;

  pim_mem_dispatcher dut (
    .clk(clk), .rst(rst),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .src_addr_a(src_addr_a), .src_addr_b(src_addr_b),
    .dest_addr(dest_addr), .size(size), .no_of_pims(no_of_pims),
    .busy(busy), .done(done),
    .pim_req_valid(pim_req_valid), .pim_req_ready(pim_req_ready),
    .pim_req_a(pim_req_a), .pim_req_b(pim_req_b),
    .pim_rsp_valid(pim_rsp_valid), .pim_rsp_data(pim_rsp_data),
    .pim_rsp_ready(pim_rsp_ready)
  );

  int          n_cmp, n_err;
  logic [15:0] ref_mem [256];
  logic [15:0] er [64];
  logic [7:0]  sa, sb, da;
  int          np_e, sz_e, n_iss, n_col;
  int          done_cnt, done_at, tk;
  logic [3:0]  used;
  bit          pend [4];
  int          cnt [4];
  logic [15:0] rd [4];
  int          lat_ch [4];
  int          hold_ch, hold_left;
  bit          lock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr_chan();
    for (int c = 0; c < 4; c++) begin
      pend[c] = 0;
      cnt[c]  = 0;
      rd[c]   = '0;
    end
  endtask

  task automatic tick();
    logic [3:0] rr, rv, fired;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      rr[c] = !(hold_left > 0 && c == hold_ch) &&
              ($urandom_range(0, 3) != 0);
      rv[c] = pend[c] && cnt[c] == 0;
      pim_rsp_data[c*16 +: 16] = rd[c];
    end
    if (hold_left > 0) hold_left--;
    pim_req_ready = rr;
    pim_rsp_valid = rv;
    host_we = lock;
    if (!lock) cmd_valid = 1'b0;
    #1;
    if (tk == 0 && sz_e > 0) begin
      chk("busy_run", busy, 1);
      chk("cmd_rdy_run", cmd_ready, 0);
    end
    if (done) begin
      done_cnt++;
      done_at = tk;
      chk("busy_done", busy, 0);
      cmd_valid = 1'b0;
      host_we = 1'b0;
      lock = 0;
    end
    chk("req_1hot", $countones(pim_req_valid) <= 1, 1);
    if (pim_req_valid != 0) chk("req_lim", n_iss < sz_e, 1);
    if (pim_rsp_ready != 0) chk("rsp_lim", n_col < n_iss, 1);
    fired = '0;
    for (int c = 0; c < 4; c++) begin
      if (pim_req_valid[c] && rr[c]) begin
        chk("req_ch", c, n_iss % np_e);
        chk("window", (n_iss - n_col) < np_e, 1);
        chk("one_out", pend[c], 0);
        chk("req_a", pim_req_a, ref_mem[8'(sa + n_iss)]);
        chk("req_b", pim_req_b, ref_mem[8'(sb + n_iss)]);
        pend[c] = 1;
        rd[c] = pim_req_a * pim_req_b;
        cnt[c] = (lat_ch[c] != 0) ? lat_ch[c] : $urandom_range(0, 3);
        used[c] = 1'b1;
        fired[c] = 1'b1;
        n_iss++;
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (rv[c] && pim_rsp_ready[c]) begin
        chk("rsp_ch", c, n_col % np_e);
        pend[c] = 0;
        n_col++;
      end else if (!fired[c] && pend[c] && cnt[c] > 0) begin
        cnt[c]--;
      end
    end
    tk++;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    ref_mem[a] = d;
  endtask

  task automatic host_rd(input logic [7:0] a, input logic [15:0] exp,
                         input string tag);
    @(negedge clk);
    host_we = 1'b0;
    host_addr = a;
    @(negedge clk);
    chk(tag, host_rdata, exp);
  endtask

  task automatic start(input logic [7:0] a_, b_, d_, input int sz, np);
    sa = a_; sb = b_; da = d_;
    np_e = (np == 0) ? 1 : ((np > 4) ? 4 : np);
    sz_e = (sz > 64) ? 64 : sz;
    n_iss = 0; n_col = 0; done_cnt = 0; done_at = -1;
    tk = 0; used = '0;
    clr_chan();
    for (int k = 0; k < sz_e; k++)
      er[k] = ref_mem[8'(a_ + k)] * ref_mem[8'(b_ + k)];
    @(negedge clk);
    host_we = 1'b0;
    cmd_valid = 1'b1;
    src_addr_a = a_;
    src_addr_b = b_;
    dest_addr = d_;
    size = 7'(sz);
    no_of_pims = 3'(np);
    host_addr = 8'hF0;
    host_wdata = 16'hDEAD;
    chk("cmd_rdy", cmd_ready, 1);
  endtask

  task automatic run_job(input logic [7:0] a_, b_, d_, input int sz, np,
                         input bit lk);
    start(a_, b_, d_, sz, np);
    lock = lk;
    while (done_cnt == 0 && tk < 3000) tick();
    if (done_cnt == 0) chk("timeout", 0, 1);
    repeat (3) tick();
    chk("done_cnt", done_cnt, 1);
    chk("n_iss", n_iss, sz_e);
    chk("n_col", n_col, sz_e);
    chk("idle_rdy", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    if (sz_e == 0) chk("done_lat", done_at, 0);
    for (int k = 0; k < sz_e; k++) ref_mem[8'(d_ + k)] = er[k];
  endtask

  task automatic verify(input logic [7:0] d_, input int n,
                        input string tag);
    for (int k = 0; k < n; k++)
      host_rd(8'(d_ + k), ref_mem[8'(d_ + k)], tag);
  endtask

  initial begin
    logic [7:0] base;
    n_cmp = 0; n_err = 0;
    rst = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    cmd_valid = 1'b0; src_addr_a = '0; src_addr_b = '0;
    dest_addr = '0; size = '0; no_of_pims = '0;
    pim_req_ready = '0; pim_rsp_valid = '0; pim_rsp_data = '0;
    for (int c = 0; c < 4; c++) lat_ch[c] = 0;
    hold_ch = 0; hold_left = 0; lock = 0;
    np_e = 1; sz_e = 0; n_iss = 0; n_col = 0; tk = 0;
    clr_chan();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_reqv", pim_req_valid, 0);
    chk("rst_rspr", pim_rsp_ready, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_cmdr", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a < 256; a++) host_wr(8'(a), 16'($urandom));
    for (int k = 0; k < 4; k++) begin
      host_wr(8'(8'h10 + k), 16'(k + 1));
      host_wr(8'(8'h20 + k), 16'(k + 5));
    end

    for (int c = 0; c < 4; c++) lat_ch[c] = 3;
    run_job(8'h10, 8'h20, 8'h30, 4, 2, 0);
    host_rd(8'h30, 16'd5, "basic0");
    host_rd(8'h31, 16'd12, "basic1");
    host_rd(8'h32, 16'd21, "basic2");
    host_rd(8'h33, 16'd32, "basic3");

    lat_ch[0] = 12; lat_ch[1] = 1; lat_ch[2] = 1; lat_ch[3] = 1;
    hold_ch = 2; hold_left = 10;
    run_job(8'h40, 8'h80, 8'hC0, 8, 4, 0);
    verify(8'hC0, 8, "bp_res");
    for (int c = 0; c < 4; c++) lat_ch[c] = 0;
    hold_left = 0;

    run_job(8'h00, 8'h50, 8'hA0, 0, 3, 0);
    chk("sz0_used", used, 0);

    run_job(8'h05, 8'h55, 8'hA5, 5, 0, 0);
    chk("np0_used", used, 4'h1);
    verify(8'hA5, 5, "np0_res");

    run_job(8'h08, 8'h58, 8'hA8, 8, 7, 0);
    chk("np7_used", used, 4'hF);
    verify(8'hA8, 8, "np7_res");

    run_job(8'h00, 8'h40, 8'h80, 64, 3, 0);
    verify(8'h80, 64, "max_res");

    run_job(8'hFE, 8'h50, 8'hFD, 4, 2, 0);
    verify(8'hFD, 4, "wrap_res");

    run_job(8'h40, 8'h60, 8'h80, 6, 2, 1);
    host_rd(8'hF0, ref_mem[8'hF0], "lock_mem");
    verify(8'h80, 6, "lock_res");

    lat_ch[0] = 2;
    start(8'h10, 8'h20, 8'h90, 6, 1);
    while (n_col < 2 && tk < 500) tick();
    chk("rst_reach", n_col, 2);
    @(negedge clk);
    rst = 1'b0;
    pim_rsp_valid = '0;
    pim_req_ready = '0;
    @(posedge clk);
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_reqv", pim_req_valid, 0);
    chk("mid_cmdr", cmd_ready, 1);
    chk("mid_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    clr_chan();
    lat_ch[0] = 0;
    ref_mem[8'h90] = er[0];
    ref_mem[8'h91] = er[1];
    verify(8'h90, 3, "mid_res");

    repeat (8) begin
      base = 8'($urandom);
      run_job(base, 8'(base + 80), 8'(base + 160),
              $urandom_range(0, 100), $urandom_range(0, 7), 0);
      verify(8'(base + 160), sz_e, "rnd_res");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
